// File: rtl/uart_rx_os_pkg.sv
// Shared types and helpers for the oversampling UART receiver.
// Optional feature macro used by the receiver: UART_RX_OS_PARITY_EN.
package uart_rx_os_pkg;

   // Receiver frame states; PARITY is only reachable when parity is compiled in.
   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      WAIT_HIGH
   } state_t;

   // Oversample counter value at which a bit is sampled (middle of the bit).
   function automatic int sample_point(input int oversample);
      return oversample / 2 - 1;
   endfunction

endpackage

// File: rtl/uart_rx_os_sync.sv
// Input conditioning for the UART receiver: 2-FF synchronizer followed by a
// 3-tap majority filter. Every stage resets to 1 so the line looks idle.
module uart_rx_os_sync (
   input  logic clk,
   input  logic reset,
   input  logic rx,
   output logic line,
   output logic sample
);

   logic [1:0] meta;
   logic [2:0] taps;

   // Synchronize the asynchronous pin and feed the majority taps.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta <= 2'b11;
         taps <= 3'b111;
      end else begin
         meta <= {meta[0], rx};
         taps <= {taps[1:0], meta[1]};
      end
   end

   // Synchronized line (start detection) and 2-of-3 vote (bit value).
   assign line   = meta[1];
   assign sample = (taps[0] & taps[1]) | (taps[0] & taps[2]) | (taps[1] & taps[2]);

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver (8N1 by default) with a one-entry valid/ready
// holding register. Defining UART_RX_OS_PARITY_EN adds an even-parity bit
// after the data bits.
//
// Handshake: m_data is transferred on every clock edge where m_valid and
// m_ready are both high; m_data is held stable while m_valid && !m_ready, and
// m_valid never depends combinationally on m_ready.
module uart_rx_os
   import uart_rx_os_pkg::*;
#(
   parameter int OVERSAMPLE = 8,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  uart_rx,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic                  frame_err,
   output logic                  overrun_err,
   output logic                  parity_err,
   output logic                  busy
);

   localparam int CW = $clog2(OVERSAMPLE);
   localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CW-1:0] SAMPLE_CNT = CW'(sample_point(OVERSAMPLE));
   localparam logic [CW-1:0] LAST_CNT   = CW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] LAST_BIT   = BW'(DATA_WIDTH - 1);

   state_t                state, state_next;
   logic [CW-1:0]         cnt, cnt_next;
   logic [BW-1:0]         bitno, bitno_next;
   logic [DATA_WIDTH-1:0] shreg;
   logic                  line, sample, at_sample;
   logic                  shift_en, stop_ok, stop_bad;
   logic                  par_bad, good, load;
`ifdef UART_RX_OS_PARITY_EN
   logic                  par_chk;
`endif

   uart_rx_os_sync u_sync (
      .clk    (clk),
      .reset  (reset),
      .rx     (uart_rx),
      .line   (line),
      .sample (sample)
   );

   // State, bit-period counter and bit index registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
         bitno <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
         bitno <= bitno_next;
      end
   end

   // Next-state logic and per-cycle strobes for the datapath.
   always_comb begin
      state_next = state;
      bitno_next = bitno;
      cnt_next   = '0;
      at_sample  = (cnt == SAMPLE_CNT);
      shift_en   = 1'b0;
      stop_ok    = 1'b0;
      stop_bad   = 1'b0;
`ifdef UART_RX_OS_PARITY_EN
      par_chk    = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (!line) state_next = START;
         end
         START: begin
            // A high vote at mid-start means the falling edge was a glitch.
            if (at_sample) begin
               if (sample) begin
                  state_next = IDLE;
               end else begin
                  state_next = DATA;
                  bitno_next = '0;
               end
            end
         end
         DATA: begin
            if (at_sample) begin
               shift_en = 1'b1;
               if (bitno == LAST_BIT) begin
                  bitno_next = '0;
`ifdef UART_RX_OS_PARITY_EN
                  state_next = PARITY;
`else
                  state_next = STOP;
`endif
               end else begin
                  bitno_next = bitno + 1'b1;
               end
            end
         end
`ifdef UART_RX_OS_PARITY_EN
         PARITY: begin
            if (at_sample) begin
               par_chk    = 1'b1;
               state_next = STOP;
            end
         end
`endif
         STOP: begin
            // Leave at the stop sample point to leave margin for the next start.
            if (at_sample) begin
               if (sample) begin
                  stop_ok    = 1'b1;
                  state_next = IDLE;
               end else begin
                  stop_bad   = 1'b1;
                  state_next = WAIT_HIGH;
               end
            end
         end
         WAIT_HIGH: begin
            if (sample) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase

      // Counter free-runs through a frame and parks at 0 when idle.
      if (state != IDLE && state_next != IDLE && state_next != WAIT_HIGH)
         cnt_next = (cnt == LAST_CNT) ? '0 : cnt + 1'b1;
   end

   // Data bits arrive LSB first.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) shreg <= '0;
      else if (shift_en) shreg <= {sample, shreg[DATA_WIDTH-1:1]};
   end

`ifdef UART_RX_OS_PARITY_EN
   // Remember a parity mismatch until the frame's stop bit is sampled.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) par_bad <= 1'b0;
      else if (state == START) par_bad <= 1'b0;
      else if (par_chk) par_bad <= (sample != ^shreg);
   end

   // Parity error pulses alongside the stop sample, whatever the stop bit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) parity_err <= 1'b0;
      else parity_err <= (stop_ok | stop_bad) & par_bad;
   end
`else
   assign par_bad    = 1'b0;
   assign parity_err = 1'b0;
`endif

   assign good = stop_ok & ~par_bad;
   assign load = good & (~m_valid | m_ready);

   // Holding register, valid flag and registered error pulses.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         m_data      <= '0;
         m_valid     <= 1'b0;
         frame_err   <= 1'b0;
         overrun_err <= 1'b0;
      end else begin
         if (load) m_data <= shreg;
         if (load) m_valid <= 1'b1;
         else if (m_ready) m_valid <= 1'b0;
         frame_err   <= stop_bad;
         overrun_err <= good & m_valid & ~m_ready;
      end
   end

   assign busy = (state != IDLE);

endmodule
